// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: write-mode encodings,
// clear-engine state type and write-port enable decoders.
package regfile_pkg;

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_P1   = 2'd1;
  localparam logic [1:0] WR_BOTH = 2'd2;
  localparam logic [1:0] WR_P2   = 2'd3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } clr_state_e;

  function automatic logic port1_en(input logic [1:0] mode);
    return (mode == WR_P1) || (mode == WR_BOTH);
  endfunction

  function automatic logic port2_en(input logic [1:0] mode);
    return (mode == WR_P2) || (mode == WR_BOTH);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Background clear engine: walks indices 0..2**ADDR_W-1, one per cycle,
// asserting a clear strobe; pulses done_o for one cycle after the last index.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // State, index counter and done pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; requests while clearing are ignored
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEARING;
          cnt_d   = '0;
        end
      end
      ST_CLEARING: begin
        clr_we_o = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o    = (state_q == ST_CLEARING);
  assign done_o    = done_q;
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised dual-write / dual-read register file with write-conflict
// resolution and a background clear engine.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// onto the read ports and RegZeroData.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [1:0]        RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic              ClearReq,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] RegZeroData,
  output logic              ClearBusy,
  output logic              ClearDone,
  output logic              WriteConflict,
  output logic              WriteDropped
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              clr_busy, clr_done, clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              we1, we2;
  logic              conflict_q, conflict_d;
  logic              dropped_q, dropped_d;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk_i      (CLOCK),
    .rst_ni     (RESET),
    .clear_req_i(ClearReq),
    .busy_o     (clr_busy),
    .done_o     (clr_done),
    .clr_we_o   (clr_we),
    .clr_idx_o  (clr_idx)
  );

  // Writes are accepted only while the clear engine is idle
  assign we1 = !clr_busy && port1_en(RegWrite);
  assign we2 = !clr_busy && port2_en(RegWrite);

  // Next array contents: port 2 applied after port 1 so it wins on equal index
  always_comb begin
    regs_d = regs_q;
    if (we1) regs_d[WriteReg1] = WriteData1;
    if (we2) regs_d[WriteReg2] = WriteData2;
    if (clr_we) regs_d[clr_idx] = RESET_VAL;
  end

  // Status pulse next-state
  always_comb begin
    conflict_d = !clr_busy && (RegWrite == WR_BOTH) && (WriteReg1 == WriteReg2);
    dropped_d  = clr_busy && (RegWrite != WR_NONE);
  end

  // Register array storage
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Registered conflict / dropped-write pulses
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      dropped_q  <= dropped_d;
    end
  end

  // Combinational read ports
  always_comb begin
    ReadData1   = regs_q[ReadReg1];
    ReadData2   = regs_q[ReadReg2];
    RegZeroData = regs_q[0];
`ifdef REGFILE_BYPASS_EN
    if (we1 && (WriteReg1 == ReadReg1)) ReadData1 = WriteData1;
    if (we2 && (WriteReg2 == ReadReg1)) ReadData1 = WriteData2;
    if (we1 && (WriteReg1 == ReadReg2)) ReadData2 = WriteData1;
    if (we2 && (WriteReg2 == ReadReg2)) ReadData2 = WriteData2;
    if (we1 && (WriteReg1 == '0)) RegZeroData = WriteData1;
    if (we2 && (WriteReg2 == '0)) RegZeroData = WriteData2;
`endif
  end

  assign ClearBusy     = clr_busy;
  assign ClearDone     = clr_done;
  assign WriteConflict = conflict_q;
  assign WriteDropped  = dropped_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: queue-based reference model, per-cycle
// comparison, directed scenarios plus randomized traffic.
module tb_regfile_mp;

  localparam logic [15:0] RV = 16'h0000;

  logic        CLOCK, RESET;
  logic [1:0]  RegWrite;
  logic [3:0]  ReadReg1, ReadReg2, WriteReg1, WriteReg2;
  logic [15:0] WriteData1, WriteData2;
  logic        ClearReq;
  logic [15:0] ReadData1, ReadData2, RegZeroData;
  logic        ClearBusy, ClearDone, WriteConflict, WriteDropped;

  int total = 0;
  int bad   = 0;

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .RESET_VAL(RV)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .RegWrite     (RegWrite),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .WriteReg1    (WriteReg1),
    .WriteReg2    (WriteReg2),
    .WriteData1   (WriteData1),
    .WriteData2   (WriteData2),
    .ClearReq     (ClearReq),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .RegZeroData  (RegZeroData),
    .ClearBusy    (ClearBusy),
    .ClearDone    (ClearDone),
    .WriteConflict(WriteConflict),
    .WriteDropped (WriteDropped)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus a queue of indices still to clear
  logic [15:0] mregs [16] = '{default: 16'h0000};
  int          clrq[$];
  bit          m_conf = 0, m_drop = 0, m_done = 0, m_busy_now;

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      foreach (mregs[i]) mregs[i] = RV;
      clrq.delete();
      m_conf = 0; m_drop = 0; m_done = 0;
    end else begin
      m_busy_now = (clrq.size() != 0);
      m_drop = m_busy_now && (RegWrite != 2'd0);
      m_conf = !m_busy_now && (RegWrite == 2'd2) && (WriteReg1 == WriteReg2);
      if (!m_busy_now) begin
        if (RegWrite == 2'd1 || RegWrite == 2'd2) mregs[WriteReg1] = WriteData1;
        if (RegWrite == 2'd2 || RegWrite == 2'd3) mregs[WriteReg2] = WriteData2;
      end
      m_done = 0;
      if (m_busy_now) begin
        mregs[clrq.pop_front()] = RV;
        if (clrq.size() == 0) m_done = 1;
      end else if (ClearReq) begin
        for (int k = 0; k < 16; k++) clrq.push_back(k);
      end
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] idx);
    logic [15:0] v;
    v = mregs[idx];
`ifdef REGFILE_BYPASS_EN
    if (clrq.size() == 0) begin
      if ((RegWrite == 2'd1 || RegWrite == 2'd2) && WriteReg1 == idx) v = WriteData1;
      if ((RegWrite == 2'd2 || RegWrite == 2'd3) && WriteReg2 == idx) v = WriteData2;
    end
`endif
    return v;
  endfunction

  // Compare DUT against the model every falling edge
  always @(negedge CLOCK) begin
    chk("ReadData1", {16'h0, ReadData1}, {16'h0, exp_rd(ReadReg1)});
    chk("ReadData2", {16'h0, ReadData2}, {16'h0, exp_rd(ReadReg2)});
    chk("RegZeroData", {16'h0, RegZeroData}, {16'h0, exp_rd(4'd0)});
    chk("ClearBusy", {31'h0, ClearBusy}, {31'h0, clrq.size() != 0});
    chk("ClearDone", {31'h0, ClearDone}, {31'h0, m_done});
    chk("WriteConflict", {31'h0, WriteConflict}, {31'h0, m_conf});
    chk("WriteDropped", {31'h0, WriteDropped}, {31'h0, m_drop});
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Counts busy cycles until ClearDone; bounded so a stuck engine cannot hang the run
  task automatic count_clear(output int n, output bit seen, input bit inject);
    n = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK);
      if (ClearBusy) n++;
      if (ClearDone) begin
        seen = 1;
        break;
      end
      #1;
      if (inject) begin
        if (i == 2) begin
          RegWrite = 2'd1; WriteReg1 = 4'd4; WriteData1 = 16'h5555;
        end
        if (i == 3) begin
          chk("dropped_literal", {31'h0, WriteDropped}, 32'h1);
          RegWrite = 2'd0;
        end
        if (i == 5) ClearReq = 1'b1;
        if (i == 6) ClearReq = 1'b0;
      end
    end
  endtask

  int n;
  bit seen;
  int dones;

  initial begin
    RESET = 1'b0; RegWrite = 2'd0; ClearReq = 1'b0;
    ReadReg1 = 4'd3; ReadReg2 = 4'd11;
    WriteReg1 = 4'd0; WriteReg2 = 4'd0; WriteData1 = 16'h0; WriteData2 = 16'h0;
    #32 RESET = 1'b1;

    // Reset state
    @(negedge CLOCK);
    chk("reset_rd1", {16'h0, ReadData1}, 32'h0);
    chk("reset_rd2", {16'h0, ReadData2}, 32'h0);
    chk("reset_flags", {28'h0, ClearBusy, ClearDone, WriteConflict, WriteDropped}, 32'h0);

    // Single-port writes
    tick(); RegWrite = 2'd1; WriteReg1 = 4'd8; WriteData1 = 16'hc78a;
    tick(); RegWrite = 2'd0; ReadReg1 = 4'd8;
    @(negedge CLOCK); chk("p1_write", {16'h0, ReadData1}, 32'hc78a);
    tick(); RegWrite = 2'd3; WriteReg2 = 4'd5; WriteData2 = 16'h1234;
    tick(); RegWrite = 2'd0; ReadReg2 = 4'd5;
    @(negedge CLOCK); chk("p2_write", {16'h0, ReadData2}, 32'h1234);

    // Dual write, same index
    tick(); RegWrite = 2'd2; WriteReg1 = 4'd3; WriteReg2 = 4'd3;
    WriteData1 = 16'h3251; WriteData2 = 16'haabb;
    tick(); RegWrite = 2'd0; ReadReg1 = 4'd3;
    @(negedge CLOCK);
    chk("conflict_data", {16'h0, ReadData1}, 32'haabb);
    chk("conflict_pulse", {31'h0, WriteConflict}, 32'h1);
    tick();
    @(negedge CLOCK); chk("conflict_clear", {31'h0, WriteConflict}, 32'h0);

    // Fill then clear
    for (int i = 0; i < 16; i++) begin
      tick(); RegWrite = 2'd1; WriteReg1 = 4'(i); WriteData1 = 16'(i * 16'h0111 + 1);
    end
    tick(); RegWrite = 2'd0; ReadReg1 = 4'd9;
    @(negedge CLOCK); chk("fill_r9", {16'h0, ReadData1}, 32'h099a);
    tick(); ClearReq = 1'b1;
    tick(); ClearReq = 1'b0;
    count_clear(n, seen, 1'b0);
    chk("clear_cycles", n, 32'd16);
    chk("clear_done_seen", {31'h0, seen}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      #0.25; ReadReg1 = 4'(i); #0.25;
      chk("cleared_reg", {16'h0, ReadData1}, {16'h0, RV});
    end

    // Clear with dropped write and ignored mid-clear request
    tick(); RegWrite = 2'd1; WriteReg1 = 4'd4; WriteData1 = 16'h4444;
    tick(); RegWrite = 2'd0; ClearReq = 1'b1;
    tick(); ClearReq = 1'b0;
    count_clear(n, seen, 1'b1);
    chk("clear2_cycles", n, 32'd16);
    chk("clear2_done_seen", {31'h0, seen}, 32'h1);

    // ClearReq held across completion restarts immediately after ClearDone
    tick(); ClearReq = 1'b1;
    tick();
    count_clear(n, seen, 1'b0);
    chk("held_done_seen", {31'h0, seen}, 32'h1);
    tick(); ClearReq = 1'b0;
    @(negedge CLOCK); chk("held_restart_busy", {31'h0, ClearBusy}, 32'h1);
    count_clear(n, seen, 1'b0);
    chk("held_second_cycles", n, 32'd15);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      tick();
      RegWrite   = 2'($urandom_range(0, 3));
      WriteReg1  = 4'($urandom_range(0, 15));
      WriteReg2  = ($urandom_range(0, 3) == 0) ? WriteReg1 : 4'($urandom_range(0, 15));
      WriteData1 = 16'($urandom);
      WriteData2 = 16'($urandom);
      ReadReg1   = 4'($urandom_range(0, 15));
      ReadReg2   = 4'($urandom_range(0, 15));
      ClearReq   = ($urandom_range(0, 39) == 0);
    end
    tick(); RegWrite = 2'd0; ClearReq = 1'b0;

    // Reset in the middle of a clear
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK);
      if (!ClearBusy) begin
        seen = 1;
        break;
      end
    end
    chk("idle_before_reset", {31'h0, seen}, 32'h1);
    tick(); RegWrite = 2'd1; WriteReg1 = 4'd15; WriteData1 = 16'h7777;
    tick(); RegWrite = 2'd0; ClearReq = 1'b1; ReadReg1 = 4'd15;
    tick(); ClearReq = 1'b0;
    repeat (5) tick();
    @(negedge CLOCK); chk("pre_reset_r15", {16'h0, ReadData1}, 32'h7777);
    tick(); RESET = 1'b0;
    @(negedge CLOCK);
    chk("midreset_busy", {31'h0, ClearBusy}, 32'h0);
    chk("midreset_r15", {16'h0, ReadData1}, {16'h0, RV});
    tick(); RESET = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      if (ClearDone) dones++;
    end
    chk("no_done_after_reset", dones, 32'd0);

`ifdef REGFILE_BYPASS_EN
    tick(); RegWrite = 2'd1; WriteReg1 = 4'd0; WriteData1 = 16'hbeef; ReadReg1 = 4'd0;
    #1;
    chk("bypass_rd1", {16'h0, ReadData1}, 32'hbeef);
    chk("bypass_zero", {16'h0, RegZeroData}, 32'hbeef);
    tick(); RegWrite = 2'd0;
`endif

    tick();
    @(negedge CLOCK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
